// File: rtl/led_frame_fifo.sv
// Synchronous FIFO for LED frame words, with occupancy count, threshold flags and error pulses.
// Define LED_FRAME_FIFO_FWFT_EN for first-word-fall-through read; default is a 1-cycle registered read.
module led_frame_fifo #(
  parameter int DATA_W   = 56,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [DATA_W-1:0]          din,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_acc;
  logic              wr_acc;
  logic [CW-1:0]     cnt_nxt;

  // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
  assign rd_acc = rd_en && !empty && !clr;
  assign wr_acc = wr_en && (!full || rd_acc) && !clr;

  always_comb begin
    cnt_nxt = count;
    if (clr)
      cnt_nxt = '0;
    else if (wr_acc && !rd_acc)
      cnt_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc)
      cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
      count        <= cnt_nxt;
      full         <= (cnt_nxt == DEPTH_C);
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      overflow     <= wr_en && !wr_acc && !clr;
      underflow    <= rd_en && !rd_acc && !clr;
    end
  end

`ifdef LED_FRAME_FIFO_FWFT_EN
  // Head of queue is always presented; rd_en only acknowledges it.
  assign dout = mem[rd_ptr];
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dout_q <= '0;
    else if (rd_acc)
      dout_q <= mem[rd_ptr];
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_led_frame_fifo.sv
// Directed self-checking bench for led_frame_fifo (DEPTH=16, DATA_W=56, AF=14, AE=2).
// Default build checks registered-read mode; an FWFT build runs a short fall-through sequence.
module tb_led_frame_fifo;

  localparam int DATA_W = 56;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [4:0]        count;
  logic              overflow;
  logic              underflow;

  int n_cmp = 0;
  int n_err = 0;

  led_frame_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    din = d; wr_en = 1'b1; rd_en = 1'b0;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1; wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) tick();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_aempty", 64'(almost_empty), 64'd1);
    check("rst_afull", 64'(almost_full), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_unf", 64'(underflow), 64'd0);
`ifndef LED_FRAME_FIFO_FWFT_EN
    check("rst_dout", 64'(dout), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

`ifndef LED_FRAME_FIFO_FWFT_EN
    // fill 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) begin
      push(DATA_W'(i));
      check($sformatf("fill_count_%0d", i), 64'(count), 64'(i));
      check($sformatf("fill_full_%0d", i), 64'(full), 64'(i == 16));
      check($sformatf("fill_afull_%0d", i), 64'(almost_full), 64'(i >= 14));
      check($sformatf("fill_aempty_%0d", i), 64'(almost_empty), 64'(i <= 2));
    end
    push(DATA_W'('hFF));
    check("ovf_pulse", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd16);
    tick();
    check("ovf_clear", 64'(overflow), 64'd0);

    for (int i = 1; i <= DEPTH; i++) begin
      pop();
      check($sformatf("drain_dout_%0d", i), 64'(dout), 64'(i));
      check($sformatf("drain_count_%0d", i), 64'(count), 64'(16 - i));
      check($sformatf("drain_empty_%0d", i), 64'(empty), 64'(i == 16));
    end
    pop();
    check("unf_pulse", 64'(underflow), 64'd1);
    check("unf_dout_hold", 64'(dout), 64'h10);
    tick();
    check("unf_clear", 64'(underflow), 64'd0);

    // two rounds of 10: second round crosses the pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) push(DATA_W'('hA0 + i));
      check($sformatf("wrap_count_%0d", r), 64'(count), 64'd10);
      for (int i = 0; i < 10; i++) begin
        pop();
        check($sformatf("wrap_dout_%0d_%0d", r, i), 64'(dout), 64'('hA0 + i));
      end
      check($sformatf("wrap_empty_%0d", r), 64'(empty), 64'd1);
      check($sformatf("wrap_zero_%0d", r), 64'(count), 64'd0);
    end

    // simultaneous read+write while full
    for (int i = 0; i < DEPTH; i++) push(DATA_W'('h20 + i));
    din = DATA_W'('h55); wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("sim_full_count", 64'(count), 64'd16);
    check("sim_full_ovf", 64'(overflow), 64'd0);
    check("sim_full_dout", 64'(dout), 64'h20);
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      check($sformatf("sim_drain_%0d", i), 64'(dout), (i < 15) ? 64'('h21 + i) : 64'h55);
    end

    // simultaneous read+write while empty
    din = DATA_W'('h66); wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("sim_empty_unf", 64'(underflow), 64'd1);
    check("sim_empty_count", 64'(count), 64'd1);
    check("sim_empty_flag", 64'(empty), 64'd0);
    pop();
    check("sim_empty_dout", 64'(dout), 64'h66);

    // flush at count 7; same-cycle write must be ignored
    for (int i = 0; i < 7; i++) push(DATA_W'('h70 + i));
    check("clr_pre_count", 64'(count), 64'd7);
    clr = 1'b1; din = DATA_W'('h77); wr_en = 1'b1;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    check("clr_count", 64'(count), 64'd0);
    check("clr_empty", 64'(empty), 64'd1);
    check("clr_aempty", 64'(almost_empty), 64'd1);
    check("clr_dout_hold", 64'(dout), 64'h66);
    push(DATA_W'('h88));
    pop();
    check("clr_after_dout", 64'(dout), 64'h88);
    check("clr_after_empty", 64'(empty), 64'd1);
`else
    push(DATA_W'('h12));
    check("fwft_dout", 64'(dout), 64'h12);
    check("fwft_empty", 64'(empty), 64'd0);
    push(DATA_W'('h34));
    check("fwft_hold", 64'(dout), 64'h12);
    pop();
    check("fwft_next", 64'(dout), 64'h34);
    check("fwft_count", 64'(count), 64'd1);
    pop();
    check("fwft_drained", 64'(empty), 64'd1);
`endif

    // asynchronous reset between edges at count 5
    for (int i = 0; i < 5; i++) push(DATA_W'('h50 + i));
    check("arst_pre_count", 64'(count), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
`ifndef LED_FRAME_FIFO_FWFT_EN
    check("arst_dout", 64'(dout), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_frame_fifo.md
Name: led_frame_fifo

Overview:
- Parametrised synchronous FIFO buffering LED frame words between the frame producer and the WS2811 serialiser.
- Generalises the fixed 56-bit LED memory FIFO: configurable width, depth and thresholds.
- Adds occupancy count, almost-full/almost-empty flags, overflow/underflow pulses and a synchronous flush.
- Single clock domain.

Parameters:
DATA_W, 56, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush, active high
din  input  DATA_W  write data
wr_en  input  1  write request
rd_en  input  1  read request
dout  output  DATA_W  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers = 0, count = 0, dout = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
  - Memory array is not reset.
  - Reset asserted mid-operation discards all contents immediately.
  - Release is synchronised by the reset tree upstream.
- Write accepted: wr_en=1 and (!full or read accepted same cycle). din is stored at wr_ptr; wr_ptr increments modulo DEPTH.
- Read accepted (standard mode): rd_en=1 and !empty. mem[rd_ptr] is registered to dout on the same edge (1-cycle read latency); rd_ptr increments modulo DEPTH. dout holds its value when no read is accepted.
- Count update per edge: +1 write only; -1 read only; unchanged when both or neither.
- Flags are registered and derived from the next count, so they are valid in the same cycle as count.
- Full with wr_en and rd_en both high: both accepted, count stays DEPTH, no overflow.
- Empty with wr_en and rd_en both high: write accepted, read rejected, underflow pulses, count becomes 1.
- wr_en while full with no read: data dropped, memory and pointers untouched, overflow=1 for one cycle.
- rd_en while empty: dout unchanged, underflow=1 for one cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count, never from pointer equality.
- clr=1: pointers and count go to 0 and flags return to their reset values on that edge; wr_en/rd_en in the same cycle are ignored; dout is retained.
- No state machine beyond the pointer/count registers; all outputs are registered.

Optional Feature:
- Macro: LED_FRAME_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout continuously shows mem[rd_ptr] whenever !empty; rd_en acts as acknowledge and advances to the next word.
  - A word written into an empty FIFO appears on dout the cycle after the write.
  - dout is undefined while empty.
  - All flags, count and pulses behave as in standard mode.
- Undefined: standard 1-cycle registered read as above.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> empty=1, full=0, count=0, almost_empty=1, dout=0.
- Fill DEPTH=16 with 0x01..0x10, then one extra write of 0xFF -> full=1 after 16th write, almost_full from 14th; extra write gives overflow pulse and count stays 16. Drain 16 reads -> dout 0x01..0x10 in order, each 1 cycle after rd_en; empty=1 after last read.
- Wrap: write 10, read 10, write 10, read 10 with values 0xA0..0xA9 -> correct order across pointer wrap, count returns to 0.
- Simultaneous: at count=16 drive wr_en=rd_en=1 with din 0x55 -> count stays 16, no overflow, 0x55 read out last. At count=0 drive both with din 0x66 -> underflow pulse, count=1.
- Flush and async reset: at count=7 assert clr -> count=0, empty=1 next edge, subsequent write/read returns the new data. Assert rst_n low between clock edges at count=5 -> count=0 and empty=1 without waiting for a clock edge.
- FWFT build: write 0x12 into empty FIFO -> dout=0x12 and empty=0 next cycle without rd_en; rd_en=1 -> dout shows next word or empty=1.
